// File: rtl/serial_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_if
// Description : Request/result handshake bundle for the bit-serial add/sub
//               unit. The ovf signal exists only when SERIAL_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_addsub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             valid;
    logic             ack;
`ifdef SERIAL_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_OVF_EN
    modport master (output start, op, a, b, ack, input ready, result, cout, valid, ovf);
    modport slave  (input start, op, a, b, ack, output ready, result, cout, valid, ovf);
`else
    modport master (output start, op, a, b, ack, input ready, result, cout, valid);
    modport slave  (input start, op, a, b, ack, output ready, result, cout, valid);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB
//               first, with a valid/ack result handshake. Optional signed
//               overflow output enabled by the SERIAL_OVF_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    serial_addsub_if.slave  bus
);

    localparam int                  c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sr;
    logic               r_op;
    logic               r_cb;
    logic               r_cout;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_ready;
    logic               w_valid;
    logic               w_x;
    logic               w_y;
    logic               w_s;
    logic               w_cnext;
    logic               w_last;
`ifdef SERIAL_OVF_EN
    logic               r_ovf;
    logic               w_ovf_next;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (bus.start) w_next = c_run;
            c_run:   if (w_last)    w_next = c_done;
            c_done:  if (bus.ack)   w_next = c_idle;
            default:                w_next = c_idle;
        endcase
    end

    // Output decode
    always_comb begin
        w_ready = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            c_idle:  w_ready = 1'b1;
            c_done:  w_valid = 1'b1;
            default: ;
        endcase
    end

    // One full-adder / full-subtractor slice; only the carry/borrow differs.
    always_comb begin
        w_x     = r_sa[0];
        w_y     = r_sb[0];
        w_s     = w_x ^ w_y ^ r_cb;
        w_last  = (r_cnt == c_last);
        w_cnext = r_op ? ((~w_x & w_y) | (~w_x & r_cb) | (w_y & r_cb))
                       : (( w_x & w_y) | ( w_x & r_cb) | (w_y & r_cb));
`ifdef SERIAL_OVF_EN
        // On the MSB slice: add uses carry-in xor carry-out, sub uses sign rule.
        w_ovf_next = r_op ? ((w_x ^ w_y) & (w_x ^ w_s)) : (r_cb ^ w_cnext);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_sr   <= '0;
            r_op   <= 1'b0;
            r_cb   <= 1'b0;
            r_cout <= 1'b0;
            r_cnt  <= '0;
`ifdef SERIAL_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_sa  <= bus.a;
                        r_sb  <= bus.b;
                        r_op  <= bus.op;
                        r_cb  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                c_run: begin
                    r_sr  <= {w_s, r_sr[WIDTH-1:1]};
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cb  <= w_cnext;
                    r_cnt <= r_cnt + c_one;
                    if (w_last) begin
                        r_cout <= w_cnext;
`ifdef SERIAL_OVF_EN
                        r_ovf  <= w_ovf_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready  = w_ready;
    assign bus.valid  = w_valid;
    assign bus.result = r_sr;
    assign bus.cout   = r_cout;
`ifdef SERIAL_OVF_EN
    assign bus.ovf    = r_ovf;
`endif

endmodule
`default_nettype wire

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial WIDTH-bit adder/subtractor built around one full-adder/full-subtractor slice and a carry/borrow flip-flop. It sits upstream of the combinational add/sub cells in the lab-cycle arithmetic path. It accepts a pair of operands plus an operation select, then processes one bit per clock, LSB first. It presents the result with a valid/ack handshake.

## Interface
- WIDTH, 4: operand and result width in bits; legal range 2 to 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an operation; sampled only when ready=1.
- op  input  1  operation select: 0 = add (a+b), 1 = subtract (a-b).
- a  input  WIDTH  operand A, captured on the accepted start.
- b  input  WIDTH  operand B, captured on the accepted start.
- ready  output  1  high in IDLE only.
- result  output  WIDTH  sum or difference, valid while valid=1.
- cout  output  1  carry-out (add) or borrow-out (sub) of the MSB.
- valid  output  1  result available; held until ack.
- ack  input  1  consumer acknowledges result; sampled only when valid=1.
- ovf  output  1  signed overflow; present only with SERIAL_OVF_EN (see Configuration).

## Operation
- States: IDLE, RUN, DONE. Internal signals: shift registers sa and sb; result shift register sr; a latched op; a carry/borrow flop cb; a bit counter cnt of width clog2(WIDTH)+1.
- IDLE: ready=1. On start=1, capture a, b, op. Clear cb to 0 and cnt to 0, then go to RUN. If start=0, stay in IDLE.
- RUN: each cycle, use x=sa[0], y=sb[0], c=cb.
  - Add: s = x^y^c; cb <= (x&y)|(x&c)|(y&c).
  - Sub: s = x^y^c; cb <= (~x&y)|(~x&c)|(y&c).
  - Shift s into the MSB of sr, shift sa and sb right, and increment cnt.
  - After the cycle with cnt=WIDTH-1, go to DONE. On that edge, cout takes the final cb.
- DONE: valid=1. result, cout and ovf are held stable. On ack=1, go to IDLE. Otherwise stay in DONE.
- start is ignored outside IDLE; operands are not re-captured.
- ack is ignored outside DONE.
- start and ack both high in DONE: the ack is taken and the state returns to IDLE. The start is ignored, because ready=0 in that cycle.
- Width rules: result wraps modulo 2^WIDTH. For sub, cout=1 iff unsigned a < b.
- Reset, asynchronous and at any time including mid-RUN, forces:
  - state=IDLE, ready=1, valid=0;
  - result=0, cout=0, ovf=0, cb=0, cnt=0.
  - Any partial operation is discarded.

## Timing
- Start accepted at rising edge k (IDLE and start=1). RUN occupies edges k+1 through k+WIDTH.
- valid rises after edge k+WIDTH, which is a latency of WIDTH cycles from acceptance.
- ready falls after edge k and rises again after the edge on which ack is sampled in DONE.
- Minimum issue interval is WIDTH+2 cycles when ack is tied high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_OVF_EN defined:
  - The ovf port and its logic are present.
  - Add: ovf = carry into the MSB XOR carry out of the MSB.
  - Sub: ovf = (a[MSB]^b[MSB]) & (a[MSB]^result[MSB]).
  - ovf updates on the same edge as cout and resets to 0.
- SERIAL_OVF_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then WIDTH=4, op=0, a=0101, b=0011, start pulse -> valid exactly 4 cycles after acceptance; result=1000, cout=0, ovf=1.
- op=1, a=0011, b=0101 -> result=1110, cout=1 (borrow), ovf=0. Also a=b=1010 -> result=0000, cout=0.
- op=0, a=1111, b=0001 -> result=0000, cout=1, ovf=0. Also a=0111, b=0001 -> ovf=1.
- Pulse start with new operands during RUN and during DONE -> ignored; the result matches the first operands. ack held low for 10 cycles -> valid and result stay stable.
- Assert rst_n=0 for one cycle on the 2nd RUN cycle -> immediately ready=1, valid=0, result=0. The next operation, op=0 with a=0001 and b=0001, gives result=0010.
- Back-to-back operations with ack tied high -> each result is correct; issue interval is WIDTH+2 cycles.
